// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared types and encodings for the RV32I multi-cycle control unit
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_LUI   = 3'b100;
  localparam logic [2:0] IMM_AUIPC = 3'b101;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // Control bundle latched in DECODE and held until the next DECODE
  typedef struct packed {
    logic [2:0] imm_sel;
    logic       asel;
    logic       bsel;
    logic [3:0] alu_sel;
    logic       br_un;
    logic [2:0] load_type;
    logic [1:0] wb_sel;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       is_jump;
    logic [2:0] funct3;
  } ctrl_t;

endpackage

// File: rtl/rv32_decode.sv
// rtl/rv32_decode.sv - combinational RV32I opcode/funct decode into the control bundle
module rv32_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  output ctrl_t       o_ctrl,
  output logic        o_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_inst;

  assign opcode      = i_inst[6:0];
  assign funct3      = i_inst[14:12];
  assign f7b5        = i_inst[30];
  assign unused_inst = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};

  // Map opcode/funct fields to datapath selects and flag unsupported encodings
  always_comb begin
    o_ctrl         = '0;
    o_ctrl.alu_sel = ALU_ADD;
    o_ctrl.funct3  = funct3;
    o_illegal      = 1'b0;
    case (opcode)
      OP_R: begin
        o_ctrl.alu_sel = {f7b5, funct3};
        o_ctrl.wb_sel  = WB_ALU;
      end
      OP_I: begin
        o_ctrl.imm_sel = IMM_I;
        o_ctrl.bsel    = 1'b1;
        // only the shift-right immediate uses bit 30 to pick arithmetic
        o_ctrl.alu_sel = {(funct3 == 3'b101) & f7b5, funct3};
        o_ctrl.wb_sel  = WB_ALU;
      end
      OP_LOAD: begin
        o_ctrl.imm_sel   = IMM_I;
        o_ctrl.bsel      = 1'b1;
        o_ctrl.wb_sel    = WB_MEM;
        o_ctrl.is_load   = 1'b1;
        o_ctrl.load_type = funct3;
        o_illegal        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        o_ctrl.imm_sel  = IMM_S;
        o_ctrl.bsel     = 1'b1;
        o_ctrl.is_store = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.imm_sel   = IMM_B;
        o_ctrl.asel      = 1'b1;
        o_ctrl.bsel      = 1'b1;
        o_ctrl.is_branch = 1'b1;
        o_ctrl.br_un     = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                           (funct3 == 3'b110) || (funct3 == 3'b111);
        o_illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        o_ctrl.imm_sel = IMM_J;
        o_ctrl.asel    = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.is_jump = 1'b1;
      end
      OP_JALR: begin
        o_ctrl.imm_sel = IMM_I;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.is_jump = 1'b1;
      end
      OP_LUI: begin
        o_ctrl.imm_sel = IMM_LUI;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.alu_sel = ALU_PASSB;
        o_ctrl.wb_sel  = WB_ALU;
      end
      OP_AUIPC: begin
        o_ctrl.imm_sel = IMM_AUIPC;
        o_ctrl.asel    = 1'b1;
        o_ctrl.bsel    = 1'b1;
        o_ctrl.wb_sel  = WB_ALU;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// rtl/rv32_multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB control FSM with ack timeout and traps
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int INSTRET_W   = 32,
  parameter int ALU_SEL_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_inst,
  input  logic                 i_br_equal,
  input  logic                 i_br_less,
  input  logic                 i_imem_ack,
  input  logic                 i_dmem_ack,
  output logic                 o_imem_req,
  output logic                 o_ir_wren,
  output logic                 o_dmem_req,
  output logic                 o_wren,
  output logic                 o_pc_wren,
  output logic                 o_pc_sel,
  output logic [2:0]           o_imm_sel,
  output logic                 o_rd_wren,
  output logic                 o_br_un,
  output logic                 o_asel,
  output logic                 o_bsel,
  output logic [ALU_SEL_W-1:0] o_alu_sel,
  output logic [2:0]           o_load_type,
  output logic [1:0]           o_wb_sel,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause,
  output logic [INSTRET_W-1:0] o_instret,
  output logic [2:0]           o_state
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t                state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [1:0]            cause_q, cause_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  ctrl_t                 dec_ctrl;
  logic                  dec_illegal;
  logic                  timeout_hit;
  logic                  br_taken;

  rv32_decode u_decode (
    .i_inst    (i_inst),
    .o_ctrl    (dec_ctrl),
    .o_illegal (dec_illegal)
  );

  // The last waiting cycle is the one whose count equals the limit; a late ack in it still wins
  assign timeout_hit = (ACK_TIMEOUT > 0) && (wait_q == WAIT_LIMIT);

  // Branch outcome from the latched funct3 and the comparator flags
  always_comb begin
    case (ctrl_q.funct3)
      3'b000:  br_taken = i_br_equal;
      3'b001:  br_taken = !i_br_equal;
      3'b100,
      3'b110:  br_taken = i_br_less;
      default: br_taken = !i_br_less;
    endcase
  end

  // Next-state, strobes and handshakes; the wait counter is zero outside FETCH/MEM waits
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    wait_d     = '0;
    cause_d    = cause_q;
    o_imem_req = 1'b0;
    o_ir_wren  = 1'b0;
    o_dmem_req = 1'b0;
    o_wren     = 1'b0;
    o_pc_wren  = 1'b0;
    o_pc_sel   = 1'b0;
    o_rd_wren  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_wren = 1'b1;
          state_d   = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        ctrl_d = dec_ctrl;
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl_q.is_branch) begin
          o_pc_wren = 1'b1;
          o_pc_sel  = br_taken;
          state_d   = ST_FETCH;
        end else if (ctrl_q.is_load || ctrl_q.is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_wren     = ctrl_q.is_store;
        if (i_dmem_ack) begin
          if (ctrl_q.is_store) begin
            o_pc_wren = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        o_rd_wren = 1'b1;
        o_pc_wren = 1'b1;
        o_pc_sel  = ctrl_q.is_jump;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    instret_d = instret_q + INSTRET_W'(o_pc_wren);
  end

  // State, latched decode bundle, wait counter, trap cause and retire counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_FETCH;
      ctrl_q    <= '0;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign o_imm_sel    = ctrl_q.imm_sel;
  assign o_br_un      = ctrl_q.br_un;
  assign o_asel       = ctrl_q.asel;
  assign o_bsel       = ctrl_q.bsel;
  assign o_alu_sel    = ALU_SEL_W'(ctrl_q.alu_sel);
  assign o_load_type  = ctrl_q.load_type;
  assign o_wb_sel     = ctrl_q.wb_sel;
  assign o_trap       = (state_q == ST_TRAP);
  assign o_trap_cause = cause_q;
  assign o_instret    = instret_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb/tb_rv32_multicycle_ctrl.sv - directed self-checking bench for rv32_multicycle_ctrl
module tb_rv32_multicycle_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_inst;
  logic        i_br_equal, i_br_less, i_imem_ack, i_dmem_ack;
  logic        o_imem_req, o_ir_wren, o_dmem_req, o_wren, o_pc_wren, o_pc_sel;
  logic [2:0]  o_imm_sel;
  logic        o_rd_wren, o_br_un, o_asel, o_bsel;
  logic [3:0]  o_alu_sel;
  logic [2:0]  o_load_type;
  logic [1:0]  o_wb_sel;
  logic        o_trap;
  logic [1:0]  o_trap_cause;
  logic [3:0]  o_instret;
  logic [2:0]  o_state;

  int total = 0;
  int bad = 0;
  int exp_ret = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_LUI  = 32'h000010B7;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_LD   = 32'h0000B183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  rv32_multicycle_ctrl #(.ACK_TIMEOUT(16), .INSTRET_W(4), .ALU_SEL_W(4)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_inst       (i_inst),
    .i_br_equal   (i_br_equal),
    .i_br_less    (i_br_less),
    .i_imem_ack   (i_imem_ack),
    .i_dmem_ack   (i_dmem_ack),
    .o_imem_req   (o_imem_req),
    .o_ir_wren    (o_ir_wren),
    .o_dmem_req   (o_dmem_req),
    .o_wren       (o_wren),
    .o_pc_wren    (o_pc_wren),
    .o_pc_sel     (o_pc_sel),
    .o_imm_sel    (o_imm_sel),
    .o_rd_wren    (o_rd_wren),
    .o_br_un      (o_br_un),
    .o_asel       (o_asel),
    .o_bsel       (o_bsel),
    .o_alu_sel    (o_alu_sel),
    .o_load_type  (o_load_type),
    .o_wb_sel     (o_wb_sel),
    .o_trap       (o_trap),
    .o_trap_cause (o_trap_cause),
    .o_instret    (o_instret),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    chk(tag, {28'd0, o_instret}, 32'(exp_ret % 16));
  endtask

  // FETCH with immediate ack; returns one tick later, in DECODE
  task automatic fetch(input logic [31:0] inst);
    i_inst     = inst;
    i_imem_ack = 1'b1;
    #1;
    chk("fetch_state", {29'd0, o_state}, 32'd0);
    chk("fetch_imem_req", {31'd0, o_imem_req}, 32'd1);
    chk("fetch_ir_wren", {31'd0, o_ir_wren}, 32'd1);
    tick();
    i_imem_ack = 1'b0;
    chk("decode_state", {29'd0, o_state}, 32'd1);
    chk("decode_ir_wren", {31'd0, o_ir_wren}, 32'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_inst = 32'd0; i_br_equal = 1'b0; i_br_less = 1'b0;
    i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
    #12;
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_imem_req", {31'd0, o_imem_req}, 32'd1);
    chk("rst_ir_wren", {31'd0, o_ir_wren}, 32'd0);
    chk("rst_dmem_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rst_pc_wren", {31'd0, o_pc_wren}, 32'd0);
    chk("rst_rd_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("rst_trap", {31'd0, o_trap}, 32'd0);
    chk("rst_cause", {30'd0, o_trap_cause}, 32'd0);
    chk("rst_alu_sel", {28'd0, o_alu_sel}, 32'd0);
    chk("rst_wb_sel", {30'd0, o_wb_sel}, 32'd0);
    chk_ret("rst_instret");
    i_reset = 1'b0;
    tick();

    // ADD x3,x1,x2: F D E W
    fetch(I_ADD);
    tick();
    chk("add_exec_state", {29'd0, o_state}, 32'd2);
    chk("add_alu_sel", {28'd0, o_alu_sel}, 32'h0);
    chk("add_wb_sel", {30'd0, o_wb_sel}, 32'd1);
    chk("add_bsel", {31'd0, o_bsel}, 32'd0);
    chk("add_exec_pc_wren", {31'd0, o_pc_wren}, 32'd0);
    tick();
    chk("add_wb_state", {29'd0, o_state}, 32'd4);
    chk("add_rd_wren", {31'd0, o_rd_wren}, 32'd1);
    chk("add_pc_wren", {31'd0, o_pc_wren}, 32'd1);
    chk("add_pc_sel", {31'd0, o_pc_sel}, 32'd0);
    chk_ret("add_instret_before");
    exp_ret++;
    tick();
    chk("add_back_fetch", {29'd0, o_state}, 32'd0);
    chk_ret("add_instret");

    // BEQ taken then not taken, BLT taken
    for (int r = 0; r < 3; r++) begin
      fetch((r == 2) ? I_BLT : I_BEQ);
      tick();
      i_br_equal = (r == 0);
      i_br_less  = (r == 2);
      #1;
      chk("br_state", {29'd0, o_state}, 32'd2);
      chk("br_pc_wren", {31'd0, o_pc_wren}, 32'd1);
      chk("br_pc_sel", {31'd0, o_pc_sel}, (r == 1) ? 32'd0 : 32'd1);
      chk("br_un", {31'd0, o_br_un}, (r == 2) ? 32'd0 : 32'd1);
      chk("br_rd_wren", {31'd0, o_rd_wren}, 32'd0);
      chk("br_imm_sel", {29'd0, o_imm_sel}, 32'd2);
      exp_ret++;
      tick();
      i_br_equal = 1'b0;
      i_br_less  = 1'b0;
      chk("br_back_fetch", {29'd0, o_state}, 32'd0);
      chk_ret("br_instret");
    end

    // LUI: PASS-B, U immediate
    fetch(I_LUI);
    tick();
    chk("lui_alu_sel", {28'd0, o_alu_sel}, 32'hF);
    chk("lui_imm_sel", {29'd0, o_imm_sel}, 32'd4);
    chk("lui_bsel", {31'd0, o_bsel}, 32'd1);
    tick();
    chk("lui_rd_wren", {31'd0, o_rd_wren}, 32'd1);
    exp_ret++;
    tick();
    chk_ret("lui_instret");

    // LW with dmem ack in the fourth MEM cycle: 8 cycles total
    fetch(I_LW);
    tick();
    chk("lw_exec_state", {29'd0, o_state}, 32'd2);
    tick();
    for (int k = 1; k <= 4; k++) begin
      i_dmem_ack = (k == 4);
      #1;
      chk("lw_mem_state", {29'd0, o_state}, 32'd3);
      chk("lw_dmem_req", {31'd0, o_dmem_req}, 32'd1);
      chk("lw_wren", {31'd0, o_wren}, 32'd0);
      chk("lw_mem_pc_wren", {31'd0, o_pc_wren}, 32'd0);
      tick();
    end
    i_dmem_ack = 1'b0;
    chk("lw_wb_state", {29'd0, o_state}, 32'd4);
    chk("lw_rd_wren", {31'd0, o_rd_wren}, 32'd1);
    chk("lw_wb_sel", {30'd0, o_wb_sel}, 32'd0);
    chk("lw_load_type", {29'd0, o_load_type}, 32'd2);
    exp_ret++;
    tick();
    chk_ret("lw_instret");

    // SW with ack on the 16th MEM cycle: ack wins over the timeout
    fetch(I_SW);
    tick();
    tick();
    for (int k = 1; k <= 16; k++) begin
      i_dmem_ack = (k == 16);
      #1;
      chk("sw_mem_state", {29'd0, o_state}, 32'd3);
      chk("sw_wren", {31'd0, o_wren}, 32'd1);
      if (k == 16) begin
        chk("sw_pc_wren", {31'd0, o_pc_wren}, 32'd1);
        chk("sw_pc_sel", {31'd0, o_pc_sel}, 32'd0);
      end
      tick();
    end
    i_dmem_ack = 1'b0;
    exp_ret++;
    chk("sw_back_fetch", {29'd0, o_state}, 32'd0);
    chk_ret("sw_instret");

    // SW with ack withheld: trap after 16 MEM cycles
    fetch(I_SW);
    tick();
    tick();
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("swto_mem_state", {29'd0, o_state}, 32'd3);
      chk("swto_dmem_req", {31'd0, o_dmem_req}, 32'd1);
      tick();
    end
    chk("to_state", {29'd0, o_state}, 32'd5);
    chk("to_trap", {31'd0, o_trap}, 32'd1);
    chk("to_cause", {30'd0, o_trap_cause}, 32'd2);
    chk("to_dmem_req", {31'd0, o_dmem_req}, 32'd0);
    chk("to_wren", {31'd0, o_wren}, 32'd0);
    chk("to_imem_req", {31'd0, o_imem_req}, 32'd0);
    chk("to_pc_wren", {31'd0, o_pc_wren}, 32'd0);
    chk("to_rd_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("to_ir_wren", {31'd0, o_ir_wren}, 32'd0);
    chk_ret("to_instret");
    tick();
    chk("to_held", {29'd0, o_state}, 32'd5);

    i_reset = 1'b1;
    #1;
    chk("to_rst_state", {29'd0, o_state}, 32'd0);
    chk("to_rst_trap", {31'd0, o_trap}, 32'd0);
    chk("to_rst_cause", {30'd0, o_trap_cause}, 32'd0);
    exp_ret = 0;
    chk_ret("to_rst_instret");
    i_reset = 1'b0;
    tick();

    // 17 ADDIs wrap the 4-bit counter to 1
    for (int n = 0; n < 17; n++) begin
      fetch(I_ADDI);
      tick();
      chk("addi_bsel", {31'd0, o_bsel}, 32'd1);
      chk("addi_alu_sel", {28'd0, o_alu_sel}, 32'h0);
      tick();
      chk("addi_rd_wren", {31'd0, o_rd_wren}, 32'd1);
      exp_ret++;
      tick();
    end
    chk("instret_wrap", {28'd0, o_instret}, 32'd1);

    // Illegal opcode: trap cause 01 after DECODE, instret unchanged
    fetch(I_BAD);
    tick();
    chk("ill_state", {29'd0, o_state}, 32'd5);
    chk("ill_trap", {31'd0, o_trap}, 32'd1);
    chk("ill_cause", {30'd0, o_trap_cause}, 32'd1);
    chk("ill_pc_wren", {31'd0, o_pc_wren}, 32'd0);
    chk_ret("ill_instret");
    i_reset = 1'b1;
    #1;
    chk("ill_rst_state", {29'd0, o_state}, 32'd0);
    chk("ill_rst_trap", {31'd0, o_trap}, 32'd0);
    exp_ret = 0;
    i_reset = 1'b0;
    tick();

    // Load funct3 011 is illegal
    fetch(I_LD);
    tick();
    chk("ld_state", {29'd0, o_state}, 32'd5);
    chk("ld_cause", {30'd0, o_trap_cause}, 32'd1);
    i_reset = 1'b1;
    #1;
    i_reset = 1'b0;
    tick();

    // Reset during a MEM wait: back to FETCH with no write strobes
    fetch(I_LW);
    tick();
    tick();
    #1;
    chk("mrst_dmem_req", {31'd0, o_dmem_req}, 32'd1);
    i_reset = 1'b1;
    #1;
    chk("mrst_state", {29'd0, o_state}, 32'd0);
    chk("mrst_dmem_req_off", {31'd0, o_dmem_req}, 32'd0);
    chk("mrst_pc_wren", {31'd0, o_pc_wren}, 32'd0);
    chk("mrst_rd_wren", {31'd0, o_rd_wren}, 32'd0);
    i_reset = 1'b0;
    tick();

    // SRAI selects arithmetic shift
    fetch(I_SRAI);
    tick();
    chk("srai_alu_sel", {28'd0, o_alu_sel}, 32'hD);
    tick();
    exp_ret++;
    tick();
    chk_ret("srai_instret");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
